crp16_muldiv: RTL and testbench

Iterative unsigned 16×16 multiply and 16/16 divide unit for the CRP16 datapath. It issues one add or subtract per cycle to an external `crp16_alu` instance, driving that ALU's `x`, `y` and `select` inputs and consuming its `alu_out` and `c`. It uses shift-add multiplication and restoring division. The pipeline controller starts the unit with a single pulse, then waits on `busy`/`done`.

---
 rtl/crp16_muldiv_if.sv | 30 +++
 rtl/crp16_muldiv.sv | 117 +++++++++++
 tb/tb_crp16_muldiv.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/crp16_muldiv_if.sv
// Bundles the crp16_muldiv request/result handshake and its external ALU drive.
// The slave side is the unit; the master side is the controller together with the ALU.
interface crp16_muldiv_if;
   logic        start;
   logic        op;
   logic [15:0] a;
   logic [15:0] b;
   logic        busy;
   logic        done;
   logic [15:0] result_lo;
   logic [15:0] result_hi;
   logic        div_by_zero;
   logic [15:0] alu_x;
   logic [15:0] alu_y;
   logic [2:0]  alu_select;
   logic [15:0] alu_out;
   logic        alu_c;

   modport slave (
      input  start, op, a, b, alu_out, alu_c,
      output busy, done, result_lo, result_hi, div_by_zero,
             alu_x, alu_y, alu_select
   );

   modport master (
      output start, op, a, b, alu_out, alu_c,
      input  busy, done, result_lo, result_hi, div_by_zero,
             alu_x, alu_y, alu_select
   );
endinterface

// File: rtl/crp16_muldiv.sv
// Iterative 16x16 shift-add multiply and 16/16 restoring divide for CRP16.
// Each RUN cycle issues one add or subtract to an external combinational ALU.
module crp16_muldiv (
   input logic clock,
   input logic reset,
   crp16_muldiv_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [2:0] SEL_ADD = 3'b110;
   localparam logic [2:0] SEL_SUB = 3'b111;

   state_t      state, state_nx;
   logic [15:0] hi, lo, opnd;
   logic [3:0]  cnt;
   logic        is_div;
   logic        dbz;
   logic        accept;
   logic        zero_div;

   // One multiply iteration: conditionally take the ALU sum, then shift {sum, lo} right.
   function automatic logic [31:0] mul_step(input logic [15:0] h, input logic [15:0] l,
                                            input logic [15:0] sum_lo, input logic carry);
      logic [16:0] sum;
      sum = l[0] ? {carry, sum_lo} : {1'b0, h};
      return {sum, l[15:1]};
   endfunction

   // One restoring-divide iteration; bit 16 of the shifted remainder forces acceptance.
   function automatic logic [31:0] div_step(input logic [15:0] h, input logic [15:0] l,
                                            input logic [15:0] diff, input logic carry);
      logic [16:0] t;
      t = {h, l[15]};
      if (t[16] || carry)
         return {diff, l[14:0], 1'b1};
      return {t[15:0], l[14:0], 1'b0};
   endfunction

   assign accept   = bus.start && (state != RUN);
   assign zero_div = bus.op && (bus.b == 16'd0);

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE, DONE: begin
            if (accept)
               state_nx = zero_div ? DONE : RUN;
            else if (state == DONE)
               state_nx = IDLE;
         end
         RUN: begin
            if (cnt == 4'd15)
               state_nx = DONE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hi     <= 16'd0;
         lo     <= 16'd0;
         opnd   <= 16'd0;
         cnt    <= 4'd0;
         is_div <= 1'b0;
         dbz    <= 1'b0;
      end else if (accept) begin
         opnd   <= bus.b;
         cnt    <= 4'd0;
         is_div <= bus.op;
         if (zero_div) begin
            hi  <= bus.a;
            lo  <= 16'hFFFF;
            dbz <= 1'b1;
         end else begin
            hi  <= 16'd0;
            lo  <= bus.a;
            dbz <= 1'b0;
         end
      end else if (state == RUN) begin
         if (is_div)
            {hi, lo} <= div_step(hi, lo, bus.alu_out, bus.alu_c);
         else
            {hi, lo} <= mul_step(hi, lo, bus.alu_out, bus.alu_c);
         cnt <= cnt + 4'd1;
      end
   end

   // ALU is parked at add-with-zeros whenever no iteration is in progress.
   always_comb begin
      bus.alu_x      = 16'd0;
      bus.alu_y      = 16'd0;
      bus.alu_select = SEL_ADD;
      if (state == RUN) begin
         bus.alu_y = opnd;
         if (is_div) begin
            bus.alu_x      = {hi[14:0], lo[15]};
            bus.alu_select = SEL_SUB;
         end else begin
            bus.alu_x = hi;
         end
      end
   end

   assign bus.busy        = (state == RUN);
   assign bus.done        = (state == DONE);
   assign bus.result_lo   = lo;
   assign bus.result_hi   = hi;
   assign bus.div_by_zero = dbz;
endmodule

// File: tb/tb_crp16_muldiv.sv
// Scoreboard bench for crp16_muldiv: a driver pushes reference results, a
// negedge monitor pops them on done and checks timing, hold and ALU idle drive.
module tb_crp16_muldiv;
   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   crp16_muldiv_if bus ();

   crp16_muldiv dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   // Behavioural ALU: 110 = add with carry-out, 111 = subtract with carry = no borrow.
   logic [16:0] alu_res;
   always_comb begin
      if (bus.alu_select == 3'b111)
         alu_res = {1'b0, bus.alu_x} - {1'b0, bus.alu_y};
      else
         alu_res = {1'b0, bus.alu_x} + {1'b0, bus.alu_y};
   end
   assign bus.alu_out = alu_res[15:0];
   assign bus.alu_c   = (bus.alu_select == 3'b111) ? (bus.alu_x >= bus.alu_y) : alu_res[16];

   typedef struct {
      logic [32:0] res;
      int          cyc;
   } exp_t;

   exp_t        q[$];
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   int          busy_start = 0;
   int          busy_end = 0;
   logic        mon_en = 1'b0;
   logic [32:0] held = 33'd0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference result as {div_by_zero, hi, lo}.
   function automatic logic [32:0] ref_op(input logic o, input logic [15:0] x, input logic [15:0] y);
      logic [31:0] p;
      if (!o) begin
         p = 32'(x) * 32'(y);
         return {1'b0, p};
      end
      if (y == 16'd0)
         return {1'b1, x, 16'hFFFF};
      return {1'b0, x % y, x / y};
   endfunction

   always @(negedge clock) begin
      if (reset) begin
         held = 33'd0;
      end else if (mon_en) begin
         check("busy", 64'(bus.busy), 64'((cyc >= busy_start) && (cyc < busy_end)));
         if (bus.done) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL spurious_done: done=1 expected 0 (cycle %0d)", cyc);
            end else begin
               exp_t e;
               e = q.pop_front();
               check("done_cycle", 64'(cyc), 64'(e.cyc));
               check("result", 64'({bus.div_by_zero, bus.result_hi, bus.result_lo}), 64'(e.res));
               held = e.res;
            end
         end else if (!bus.busy) begin
            check("hold", 64'({bus.div_by_zero, bus.result_hi, bus.result_lo}), 64'(held));
         end
         if (!bus.busy)
            check("alu_idle", 64'({bus.alu_x, bus.alu_y, bus.alu_select}), {29'd0, 32'd0, 3'b110});
      end
   end

   // Called at a negedge while the unit can accept a start.
   task automatic issue(input logic o, input logic [15:0] x, input logic [15:0] y);
      exp_t e;
      logic zd;
      zd = o && (y == 16'd0);
      bus.start = 1'b1;
      bus.op = o;
      bus.a = x;
      bus.b = y;
      e.res = ref_op(o, x, y);
      e.cyc = cyc + (zd ? 1 : 17);
      q.push_back(e);
      busy_start = cyc + 1;
      busy_end = zd ? cyc + 1 : cyc + 17;
      @(negedge clock);
      bus.start = 1'b0;
      bus.op = 1'($urandom);
      bus.a = 16'($urandom);
      bus.b = 16'($urandom);
   endtask

   task automatic wait_done();
      int n = 0;
      while (!bus.done && n < 40) begin
         @(negedge clock);
         n++;
      end
      if (!bus.done) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: done=0 expected 1 (cycle %0d)", cyc);
      end
   endtask

   initial begin
      logic        o;
      logic [15:0] x, y;
      bus.start = 1'b0;
      bus.op = 1'b0;
      bus.a = 16'd0;
      bus.b = 16'd0;
      repeat (2) @(negedge clock);
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_done", 64'(bus.done), 64'd0);
      check("rst_result", 64'({bus.div_by_zero, bus.result_hi, bus.result_lo}), 64'd0);
      check("rst_alu", 64'({bus.alu_x, bus.alu_y, bus.alu_select}), 64'(3'b110));
      reset = 1'b0;
      mon_en = 1'b1;
      @(negedge clock);

      issue(1'b0, 16'h1234, 16'h5678); wait_done(); @(negedge clock);
      issue(1'b0, 16'hFFFF, 16'hFFFF); wait_done(); @(negedge clock);
      issue(1'b0, 16'h0000, 16'hFFFF); wait_done(); @(negedge clock);
      issue(1'b1, 16'd1000, 16'd7);    wait_done(); @(negedge clock);
      issue(1'b1, 16'hFFFF, 16'h0001); wait_done(); @(negedge clock);
      issue(1'b1, 16'hFFFF, 16'h8001); wait_done(); @(negedge clock);
      issue(1'b1, 16'h1234, 16'h0000); wait_done(); @(negedge clock);
      issue(1'b1, 16'd50, 16'd5);      wait_done();

      // Back-to-back: second start lands in the done cycle.
      issue(1'b0, 16'hABCD, 16'h0102); wait_done();
      issue(1'b1, 16'hBEEF, 16'h0013); wait_done(); @(negedge clock);

      // A start during RUN must be ignored.
      issue(1'b0, 16'h00FF, 16'h0101);
      repeat (4) @(negedge clock);
      bus.start = 1'b1; bus.op = 1'b1; bus.a = 16'h5555; bus.b = 16'h0000;
      @(negedge clock);
      bus.start = 1'b0;
      wait_done(); @(negedge clock);

      // Asynchronous reset at RUN cycle 8 discards the operation.
      issue(1'b0, 16'h4321, 16'h8765);
      repeat (7) @(negedge clock);
      #2 reset = 1'b1;
      #1;
      check("midrst_busy", 64'(bus.busy), 64'd0);
      check("midrst_done", 64'(bus.done), 64'd0);
      check("midrst_result", 64'({bus.div_by_zero, bus.result_hi, bus.result_lo}), 64'd0);
      check("midrst_alu", 64'({bus.alu_x, bus.alu_y, bus.alu_select}), 64'(3'b110));
      q.delete();
      busy_start = 0;
      busy_end = 0;
      @(negedge clock);
      #2 reset = 1'b0;
      repeat (20) @(negedge clock);

      for (int i = 0; i < 60; i++) begin
         o = 1'($urandom);
         x = 16'($urandom);
         case ($urandom_range(0, 7))
            0:       y = 16'd0;
            1:       y = 16'($urandom_range(1, 15));
            2:       y = 16'hFFFF;
            default: y = 16'($urandom);
         endcase
         issue(o, x, y);
         wait_done();
         repeat ($urandom_range(0, 2)) @(negedge clock);
      end

      repeat (3) @(negedge clock);
      if (q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL pending: %0d results outstanding expected 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
